// File: rtl/rf_wport_arbiter_if.sv
// rf_wport_arbiter_if: writeback, multicycle-return and register-file write port bundle
interface rf_wport_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 32,
    parameter int CW = 3
);
    logic          pipe_we;
    logic [AW-1:0] pipe_addr;
    logic [DW-1:0] pipe_data;
    logic          mc_valid;
    logic          mc_ready;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_data;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          pipe_stall;
    logic          proto_err;
    logic [CW-1:0] fifo_count;

    modport master (
        output pipe_we, pipe_addr, pipe_data, mc_valid, mc_addr, mc_data,
        input  mc_ready, rf_we, rf_addr, rf_data, pipe_stall, proto_err, fifo_count
    );

    modport slave (
        input  pipe_we, pipe_addr, pipe_data, mc_valid, mc_addr, mc_data,
        output mc_ready, rf_we, rf_addr, rf_data, pipe_stall, proto_err, fifo_count
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: register-file write port owner, writeback first, multicycle results via FIFO
module rf_wport_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3,
    parameter int AW           = 4,
    parameter int DW           = 32
) (
    input logic               clk,
    input logic               rst_n,
    rf_wport_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_vld, r_kill;
    logic [PW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_starve;
    logic             r_we, r_stall, r_perr;
    logic [AW-1:0]    r_rf_addr;
    logic [DW-1:0]    r_rf_data;

    logic             w_full, w_head, w_hkill, w_enq, w_deq, w_blocked, w_stall_n;
    logic [SW-1:0]    w_starve_n;
    logic [DEPTH-1:0] w_vld_n, w_kill_n;

    always_comb begin
        w_full     = r_count == CW'(DEPTH);
        w_head     = r_count != '0;
        w_hkill    = r_kill[r_rp];
        w_enq      = bus.mc_valid && !w_full;
        w_deq      = w_head && (w_hkill || !bus.pipe_we);
        w_blocked  = w_head && !w_hkill && bus.pipe_we;
        w_starve_n = !w_blocked ? '0 : (r_starve == SW'(STARVE_LIMIT)) ? r_starve : r_starve + 1'b1;
        w_stall_n  = w_deq ? 1'b0 : (w_blocked && w_starve_n == SW'(STARVE_LIMIT)) ? 1'b1 : r_stall;
        w_vld_n    = r_vld;
        w_kill_n   = r_kill;
        // a writeback kills every older queued result to the same register, including one arriving now
        for (int i = 0; i < DEPTH; i++) begin
            w_vld_n[i]  = (w_enq && r_wp == PW'(i)) | (r_vld[i] & ~(w_deq && r_rp == PW'(i)));
            w_kill_n[i] = (w_enq && r_wp == PW'(i)) ? (bus.pipe_we && bus.mc_addr == bus.pipe_addr) :
                          ~(w_deq && r_rp == PW'(i)) &
                          (r_kill[i] | (bus.pipe_we & r_vld[i] & (r_addr[i] == bus.pipe_addr)));
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_wp] <= bus.mc_addr;
            r_data[r_wp] <= bus.mc_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= '0;
            r_kill    <= '0;
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_stall   <= 1'b0;
            r_perr    <= 1'b0;
            r_we      <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else begin
            r_vld    <= w_vld_n;
            r_kill   <= w_kill_n;
            r_wp     <= r_wp + PW'(w_enq);
            r_rp     <= r_rp + PW'(w_deq);
            r_count  <= r_count + CW'(w_enq) - CW'(w_deq);
            r_starve <= w_starve_n;
            r_stall  <= w_stall_n;
            r_perr   <= r_perr | (bus.pipe_we & r_stall);
            if (bus.pipe_we) begin
                r_we      <= 1'b1;
                r_rf_addr <= bus.pipe_addr;
                r_rf_data <= bus.pipe_data;
            end else if (w_head && !w_hkill) begin
                r_we      <= 1'b1;
                r_rf_addr <= r_addr[r_rp];
                r_rf_data <= r_data[r_rp];
            end else begin
                r_we      <= 1'b0;
            end
        end
    end

    assign bus.mc_ready   = !w_full;
    assign bus.rf_we      = r_we;
    assign bus.rf_addr    = r_rf_addr;
    assign bus.rf_data    = r_rf_data;
    assign bus.pipe_stall = r_stall;
    assign bus.proto_err  = r_perr;
    assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: random and directed stimulus checked against a queue-based model
module tb_rf_wport_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
        logic        k;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    ent_t        q[$];
    logic        m_we = 1'b0, m_stall = 1'b0, m_perr = 1'b0;
    logic [3:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          m_st = 0;

    rf_wport_arbiter_if #(.AW(4), .DW(32), .CW(3)) bus ();

    rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .AW(4), .DW(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pw, input logic [3:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [3:0] ma, input logic [31:0] md);
        bus.pipe_we   = pw;
        bus.pipe_addr = pa;
        bus.pipe_data = pd;
        bus.mc_valid  = mv;
        bus.mc_addr   = ma;
        bus.mc_data   = md;
    endtask

    // Compare at the falling edge, then advance the model with the inputs the next rising edge will see
    initial begin
        ent_t e;
        bit   hv, hk, enq, deq, blk;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                m_we = 0; m_addr = 0; m_data = 0; m_stall = 0; m_perr = 0; m_st = 0;
            end
            chk("rf_we", {31'd0, bus.rf_we}, {31'd0, m_we});
            chk("rf_addr", {28'd0, bus.rf_addr}, {28'd0, m_addr});
            chk("rf_data", bus.rf_data, m_data);
            chk("pipe_stall", {31'd0, bus.pipe_stall}, {31'd0, m_stall});
            chk("proto_err", {31'd0, bus.proto_err}, {31'd0, m_perr});
            chk("fifo_count", {29'd0, bus.fifo_count}, q.size());
            chk("mc_ready", {31'd0, bus.mc_ready}, {31'd0, q.size() < DEPTH});
            if (rst_n) begin
                hv  = q.size() > 0;
                hk  = hv && q[0].k;
                enq = bus.mc_valid && q.size() < DEPTH;
                deq = hv && (hk || !bus.pipe_we);
                blk = hv && !hk && bus.pipe_we;
                if (bus.pipe_we) begin
                    m_we = 1; m_addr = bus.pipe_addr; m_data = bus.pipe_data;
                end else if (hv && !hk) begin
                    m_we = 1; m_addr = q[0].a; m_data = q[0].d;
                end else m_we = 0;
                if (bus.pipe_we && m_stall) m_perr = 1;
                m_st = blk ? m_st + 1 : 0;
                if (deq) m_stall = 0;
                else if (blk && m_st >= LIMIT) m_stall = 1;
                if (deq) void'(q.pop_front());
                if (enq) begin
                    e.a = bus.mc_addr; e.d = bus.mc_data; e.k = 0;
                    q.push_back(e);
                end
                if (bus.pipe_we) foreach (q[i]) if (q[i].a == bus.pipe_addr) q[i].k = 1;
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("reset rf_we", {31'd0, bus.rf_we}, 0);
        chk("reset fifo_count", {29'd0, bus.fifo_count}, 0);
        chk("reset pipe_stall", {31'd0, bus.pipe_stall}, 0);
        @(posedge clk); #3;
        rst_n = 1;
        // 1: writeback from idle
        drive(1, 3, 32'hA5A5A5A5, 0, 0, 0);
        step();
        chk("t1 rf_we", {31'd0, bus.rf_we}, 1);
        chk("t1 rf_addr", {28'd0, bus.rf_addr}, 3);
        chk("t1 rf_data", bus.rf_data, 32'hA5A5A5A5);
        chk("t1 mc_ready", {31'd0, bus.mc_ready}, 1);
        chk("t1 fifo_count", {29'd0, bus.fifo_count}, 0);
        // 2: single multicycle result
        drive(0, 0, 0, 1, 5, 32'h1234);
        step();
        chk("t2 count N+1", {29'd0, bus.fifo_count}, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("t2 rf_we", {31'd0, bus.rf_we}, 1);
        chk("t2 rf_addr", {28'd0, bus.rf_addr}, 5);
        chk("t2 rf_data", bus.rf_data, 32'h1234);
        chk("t2 count N+2", {29'd0, bus.fifo_count}, 0);
        step();
        // 3: fill while writeback holds the port
        for (int i = 1; i <= 4; i++) begin
            drive(1, 15, $urandom, 1, 4'(i), 32'(100 + i));
            step();
        end
        chk("t3 full count", {29'd0, bus.fifo_count}, 4);
        chk("t3 mc_ready", {31'd0, bus.mc_ready}, 0);
        chk("t3 stall", {31'd0, bus.pipe_stall}, 1);
        drive(0, 0, 0, 1, 9, 32'h99);
        step();
        chk("t3 held off", {29'd0, bus.fifo_count}, 3);
        chk("t3 drain1", {28'd0, bus.rf_addr}, 1);
        chk("t3 data1", bus.rf_data, 101);
        chk("t3 stall clear", {31'd0, bus.pipe_stall}, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("t3 drain we", {31'd0, bus.rf_we}, 1);
            chk("t3 drain addr", {28'd0, bus.rf_addr}, i);
        end
        chk("t3 proto_err", {31'd0, bus.proto_err}, 0);
        step();
        // 4: WAW squash
        drive(0, 0, 0, 1, 7, 32'h11);
        step();
        drive(1, 7, 32'h22, 0, 0, 0);
        step();
        chk("t4 pipe we", {31'd0, bus.rf_we}, 1);
        chk("t4 pipe data", bus.rf_data, 32'h22);
        chk("t4 count", {29'd0, bus.fifo_count}, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("t4 killed we", {31'd0, bus.rf_we}, 0);
        chk("t4 killed count", {29'd0, bus.fifo_count}, 0);
        chk("t4 hold data", bus.rf_data, 32'h22);
        // 5: starvation, contract respected
        drive(1, 12, 32'hAA, 1, 2, 32'h55);
        step();
        drive(1, 12, 32'hAB, 0, 0, 0);
        step();
        step();
        chk("t5 no stall yet", {31'd0, bus.pipe_stall}, 0);
        step();
        chk("t5 stall", {31'd0, bus.pipe_stall}, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("t5 head addr", {28'd0, bus.rf_addr}, 2);
        chk("t5 head data", bus.rf_data, 32'h55);
        chk("t5 stall clear", {31'd0, bus.pipe_stall}, 0);
        chk("t5 proto_err", {31'd0, bus.proto_err}, 0);
        // 5 variant: writeback during stall
        drive(1, 12, 32'hAC, 1, 3, 32'h66);
        step();
        drive(1, 12, 32'hAD, 0, 0, 0);
        repeat (3) step();
        chk("t5v stall", {31'd0, bus.pipe_stall}, 1);
        step();
        chk("t5v proto_err", {31'd0, bus.proto_err}, 1);
        chk("t5v pipe wins", {28'd0, bus.rf_addr}, 12);
        chk("t5v still stalled", {31'd0, bus.pipe_stall}, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("t5v head data", bus.rf_data, 32'h66);
        chk("t5v stall clear", {31'd0, bus.pipe_stall}, 0);
        // random traffic on a small address range to provoke collisions
        for (int c = 0; c < 2000; c++) begin
            drive(m_stall ? ($urandom_range(0, 19) == 0) : 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) step();
        // 6: async reset mid-drain
        for (int i = 1; i <= 3; i++) begin
            drive(1, 4'(9 + i), 32'(i), 1, 4'(i), 32'(200 + i));
            step();
        end
        chk("t6 count", {29'd0, bus.fifo_count}, 3);
        chk("t6 we before", {31'd0, bus.rf_we}, 1);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        chk("t6 rst rf_we", {31'd0, bus.rf_we}, 0);
        chk("t6 rst count", {29'd0, bus.fifo_count}, 0);
        chk("t6 rst stall", {31'd0, bus.pipe_stall}, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6 no write", {31'd0, bus.rf_we}, 0);
            chk("t6 empty", {29'd0, bus.fifo_count}, 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
